// File: rtl/lsq_mem_arbiter.sv
// lsq_mem_arbiter: shares the single data-memory port between LSQ loads and
// retired stores. Stores win on a same-word address hazard or once loads
// have starved them for STARVE_LIMIT grants in a row. One access is in
// flight at a time. The request is held stable until mem_ack arrives.
module lsq_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 64
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ld_valid,
   input  logic [31:0] ld_pc,
   input  logic [31:0] ld_addr,
   output logic        ld_ready,
   input  logic        st_valid,
   input  logic [31:0] st_pc,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        ld_done,
   output logic [31:0] ld_done_pc,
   output logic [31:0] ld_data,
   output logic        st_done,
   output logic [31:0] st_done_pc,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT} state_t;

   state_t      state;
   logic [7:0]  streak;
   logic [7:0]  tmo_cnt;
   logic [31:0] pc_lat;
   logic        hazard;
   logic        starve;
   logic        grant_ld;
   logic        grant_st;
   logic        ack_seen;

   // Arbitration: hazard, then starvation, then load, then store; IDLE only.
   always_comb begin
      hazard   = st_valid & ld_valid & (st_addr[31:2] == ld_addr[31:2]);
      starve   = st_valid & (streak == 8'(STARVE_LIMIT));
      grant_ld = 1'b0;
      grant_st = 1'b0;
      if (state == IDLE) begin
         if (hazard || starve) begin
            grant_st = 1'b1;
         end else if (ld_valid) begin
            grant_ld = 1'b1;
         end else if (st_valid) begin
            grant_st = 1'b1;
         end
      end
   end

   assign ld_ready = grant_ld;
   assign st_ready = grant_st;
   // An ack only counts while a request is actually outstanding.
   assign ack_seen = mem_req & mem_ack;

   // Count loads granted past a waiting store; any store grant or idle store side clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         streak <= 8'd0;
      end else if (!st_valid || grant_st) begin
         streak <= 8'd0;
      end else if (grant_ld && (streak != 8'hFF)) begin
         streak <= streak + 8'd1;
      end
   end

   // Main FSM: latch the granted request, wait for ack, pulse completion, track timeout.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         busy       <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         ld_done    <= 1'b0;
         ld_done_pc <= 32'd0;
         ld_data    <= 32'd0;
         st_done    <= 1'b0;
         st_done_pc <= 32'd0;
         err        <= 1'b0;
         tmo_cnt    <= 8'd0;
         pc_lat     <= 32'd0;
      end else begin
         ld_done <= 1'b0;
         st_done <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_ld) begin
                  state    <= LD_WAIT;
                  busy     <= 1'b1;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= ld_addr;
                  pc_lat   <= ld_pc;
                  tmo_cnt  <= 8'd0;
               end else if (grant_st) begin
                  state     <= ST_WAIT;
                  busy      <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= st_addr;
                  mem_wdata <= st_data;
                  pc_lat    <= st_pc;
                  tmo_cnt   <= 8'd0;
               end
            end
            LD_WAIT, ST_WAIT: begin
               if (ack_seen) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  mem_req <= 1'b0;
                  if (state == LD_WAIT) begin
                     ld_done    <= 1'b1;
                     ld_done_pc <= pc_lat;
                     ld_data    <= mem_rdata;
                  end else begin
                     st_done    <= 1'b1;
                     st_done_pc <= pc_lat;
                  end
               end else begin
                  // Keep waiting; err latches once the wait hits TIMEOUT cycles.
                  if (tmo_cnt != 8'hFF) begin
                     tmo_cnt <= tmo_cnt + 8'd1;
                  end
                  if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                     err <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Scoreboard bench for lsq_mem_arbiter: stimulus queues expected memory
// requests and completions, a monitor pops and compares them as they appear.
module tb_lsq_mem_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ld_valid, st_valid, mem_ack;
   logic [31:0] ld_pc, ld_addr, st_pc, st_addr, st_data, mem_rdata;
   logic        ld_ready, st_ready, mem_req, mem_we, ld_done, st_done, busy, err;
   logic [31:0] mem_addr, mem_wdata, ld_done_pc, ld_data, st_done_pc;

   int checks = 0;
   int errors = 0;

   typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata;} req_t;
   typedef struct {bit st; logic [31:0] pc; logic [31:0] data;} done_t;
   req_t  req_q[$];
   done_t done_q[$];

   int          ack_delay = 0;
   int          wait_cnt  = 0;
   logic [31:0] rdata_val = 32'd0;

   always #5 clk = ~clk;

   lsq_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
      .clk(clk), .rstn(rstn),
      .ld_valid(ld_valid), .ld_pc(ld_pc), .ld_addr(ld_addr), .ld_ready(ld_ready),
      .st_valid(st_valid), .st_pc(st_pc), .st_addr(st_addr), .st_data(st_data),
      .st_ready(st_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ld_done(ld_done), .ld_done_pc(ld_done_pc), .ld_data(ld_data),
      .st_done(st_done), .st_done_pc(st_done_pc),
      .busy(busy), .err(err)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic req_t mk_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      req_t r;
      r.we = we; r.addr = addr; r.wdata = wdata;
      return r;
   endfunction

   function automatic done_t mk_done(input bit st, input logic [31:0] pc, input logic [31:0] data);
      done_t d;
      d.st = st; d.pc = pc; d.data = data;
      return d;
   endfunction

   // Memory model: ack after ack_delay request cycles.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(posedge clk); #1;
         if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = rdata_val;
            end else begin
               mem_ack   = 1'b0;
               mem_rdata = 32'd0;
            end
            wait_cnt++;
         end else begin
            wait_cnt = 0;
            mem_ack  = 1'b0;
         end
      end
   end

   // Monitor: compares request issue, request stability, ready gating and completions.
   initial begin
      req_t  cur;
      done_t d;
      bit    prev = 1'b0;
      cur = mk_req(1'b0, 32'd0, 32'd0);
      forever begin
         @(negedge clk);
         if (mem_req && !prev) begin
            if (req_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_req: got addr %h we %0d expected none", mem_addr, mem_we);
            end else begin
               cur = req_q.pop_front();
               check32("req_we", {31'd0, mem_we}, {31'd0, cur.we});
               check32("req_addr", mem_addr, cur.addr);
               if (cur.we) check32("req_wdata", mem_wdata, cur.wdata);
            end
            cur = mk_req(mem_we, mem_addr, mem_wdata);
         end else if (mem_req) begin
            check32("hold_we", {31'd0, mem_we}, {31'd0, cur.we});
            check32("hold_addr", mem_addr, cur.addr);
            check32("hold_wdata", mem_wdata, cur.wdata);
         end
         if (busy) check32("ready_while_busy", {30'd0, ld_ready, st_ready}, 32'd0);
         if (ld_done || st_done) begin
            if (done_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got ld_done %0d st_done %0d expected none", ld_done, st_done);
            end else begin
               d = done_q.pop_front();
               check32("done_kind", {30'd0, st_done, ld_done}, d.st ? 32'd2 : 32'd1);
               check32("done_pc", d.st ? st_done_pc : ld_done_pc, d.pc);
               if (!d.st) check32("ld_data", ld_data, d.data);
            end
         end
         prev = mem_req;
      end
   end

   task automatic do_load(input logic [31:0] pc, input logic [31:0] addr, input bit keep,
                          output bit ok, output bit std_at_grant);
      ok = 1'b0; std_at_grant = 1'b0;
      ld_valid = 1'b1; ld_pc = pc; ld_addr = addr;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ld_ready) begin
            ok = 1'b1;
            std_at_grant = st_done;
            break;
         end
      end
      @(posedge clk); #1;
      if (!keep) ld_valid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL ld_grant_timeout: got no grant expected grant for pc %h", pc);
      end
   endtask

   task automatic do_store(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
      bit ok = 1'b0;
      st_valid = 1'b1; st_pc = pc; st_addr = addr; st_data = data;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (st_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      st_valid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL st_grant_timeout: got no grant expected grant for pc %h", pc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok, sdg, ok2, dummy;
      int cnt;
      rstn = 1'b0;
      ld_valid = 1'b0; ld_pc = 32'd0; ld_addr = 32'd0;
      st_valid = 1'b0; st_pc = 32'd0; st_addr = 32'd0; st_data = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      check32("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check32("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check32("rst_mem_addr", mem_addr, 32'd0);
      check32("rst_mem_wdata", mem_wdata, 32'd0);
      check32("rst_dones", {30'd0, ld_done, st_done}, 32'd0);
      check32("rst_done_pcs", ld_done_pc | st_done_pc | ld_data, 32'd0);
      check32("rst_busy_err", {30'd0, busy, err}, 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Reset mid-access: request dropped asynchronously, nothing completes
      ack_delay = 1000;
      req_q.push_back(mk_req(1'b0, 32'h80, 32'd0));
      do_load(32'h8, 32'h80, 1'b0, ok, dummy);
      @(posedge clk); #1;
      check32("midrst_req_before", {31'd0, mem_req}, 32'd1);
      rstn = 1'b0;
      #1;
      check32("midrst_req_async", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      ack_delay = 0;
      repeat (3) @(posedge clk);
      #1;
      check32("midrst_idle", {30'd0, busy, err}, 32'd0);

      // Single load, zero wait
      rdata_val = 32'hDEADBEEF;
      req_q.push_back(mk_req(1'b0, 32'h100, 32'd0));
      done_q.push_back(mk_done(1'b0, 32'h10, 32'hDEADBEEF));
      do_load(32'h10, 32'h100, 1'b0, ok, dummy);
      check32("ld_done_early", {31'd0, ld_done}, 32'd0);
      @(posedge clk); #1;
      check32("ld_done_latency", {31'd0, ld_done}, 32'd1);
      @(posedge clk); #1;
      check32("ld_done_pulse", {31'd0, ld_done}, 32'd0);
      check32("ld_done_pc_hold", ld_done_pc, 32'h10);

      // Address hazard: store to same word wins, load follows on st_done
      rdata_val = 32'h12345678;
      req_q.push_back(mk_req(1'b1, 32'h203, 32'h55));
      req_q.push_back(mk_req(1'b0, 32'h200, 32'd0));
      done_q.push_back(mk_done(1'b1, 32'h30, 32'd0));
      done_q.push_back(mk_done(1'b0, 32'h20, 32'h12345678));
      fork
         do_store(32'h30, 32'h203, 32'h55);
         do_load(32'h20, 32'h200, 1'b0, ok2, sdg);
      join
      check32("hazard_ld_with_st_done", {31'd0, sdg}, 32'd1);
      repeat (3) @(posedge clk);
      #1;

      // Starvation: four loads, then the store, then loads resume
      rdata_val = 32'hCAFE0000;
      for (int i = 0; i < 4; i++) begin
         req_q.push_back(mk_req(1'b0, 32'h400 + 32'(4 * i), 32'd0));
         done_q.push_back(mk_done(1'b0, 32'h40 + 32'(4 * i), 32'hCAFE0000));
      end
      req_q.push_back(mk_req(1'b1, 32'h300, 32'h77));
      done_q.push_back(mk_done(1'b1, 32'h90, 32'd0));
      for (int i = 4; i < 6; i++) begin
         req_q.push_back(mk_req(1'b0, 32'h400 + 32'(4 * i), 32'd0));
         done_q.push_back(mk_done(1'b0, 32'h40 + 32'(4 * i), 32'hCAFE0000));
      end
      fork
         begin
            bit lok, ldum;
            for (int i = 0; i < 6; i++)
               do_load(32'h40 + 32'(4 * i), 32'h400 + 32'(4 * i), i < 5, lok, ldum);
         end
         do_store(32'h90, 32'h300, 32'h77);
      join
      repeat (3) @(posedge clk);
      #1;

      // Wait states: ack after 5 extra cycles, six request cycles
      rdata_val = 32'h0BADF00D;
      ack_delay = 5;
      req_q.push_back(mk_req(1'b0, 32'h500, 32'd0));
      done_q.push_back(mk_done(1'b0, 32'h50, 32'h0BADF00D));
      do_load(32'h50, 32'h500, 1'b0, ok, dummy);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!mem_req) break;
         cnt++;
         @(posedge clk); #1;
      end
      check32("wait_req_cycles", cnt, 32'd6);
      check32("wait_done_pulse", {31'd0, ld_done}, 32'd1);
      ack_delay = 0;
      repeat (2) @(posedge clk);
      #1;

      // Timeout: err after 8 WAIT cycles, sticky through a later ack
      rdata_val = 32'h600D600D;
      ack_delay = 1000;
      req_q.push_back(mk_req(1'b0, 32'h600, 32'd0));
      done_q.push_back(mk_done(1'b0, 32'h60, 32'h600D600D));
      do_load(32'h60, 32'h600, 1'b0, ok, dummy);
      repeat (7) @(posedge clk);
      #1;
      check32("err_before_limit", {31'd0, err}, 32'd0);
      @(posedge clk); #1;
      check32("err_at_limit", {31'd0, err}, 32'd1);
      check32("still_waiting", {30'd0, busy, mem_req}, 32'd3);
      ack_delay = 0;
      repeat (4) @(posedge clk);
      #1;
      check32("err_sticky", {31'd0, err}, 32'd1);
      check32("idle_after_late_ack", {31'd0, busy}, 32'd0);

      repeat (2) @(posedge clk);
      check32("req_q_left", req_q.size(), 32'd0);
      check32("done_q_left", done_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsq_mem_arbiter.md
Name: lsq_mem_arbiter

Overview:
- Schedules the single data-memory port between two requesters: loads issued from the load-store queue, and retired stores draining toward memory.
- Grants one request at a time and holds the memory request stable until the memory acknowledges it.
- Returns load data tagged with the instruction PC, and reports store completion by PC.
- Sits between the LSQ issue/retire path and the data memory. Enforces store-before-load ordering on matching addresses and prevents store starvation.

Parameters:
- STARVE_LIMIT, 4: number of consecutive load grants allowed while a store is waiting before the store is forced; legal range 1..255.
- TIMEOUT, 64: number of cycles the block waits for mem_ack before raising err; legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- ld_valid  in  1  load request pending.
- ld_pc  in  32  PC of the load.
- ld_addr  in  32  effective address of the load.
- ld_ready  out  1  load accepted this cycle when ld_valid & ld_ready.
- st_valid  in  1  retired store pending.
- st_pc  in  32  PC of the store.
- st_addr  in  32  effective address of the store.
- st_data  in  32  store data.
- st_ready  out  1  store accepted this cycle when st_valid & st_ready.
- mem_req  out  1  memory access request (registered).
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  memory completed the access; sampled only while mem_req = 1.
- mem_rdata  in  32  read data, valid in the mem_ack cycle.
- ld_done  out  1  one-cycle pulse: load data returned.
- ld_done_pc  out  32  PC of the completed load.
- ld_data  out  32  data of the completed load.
- st_done  out  1  one-cycle pulse: store written.
- st_done_pc  out  32  PC of the completed store.
- busy  out  1  1 when state is not IDLE.
- err  out  1  sticky timeout flag, cleared only by reset.

Behaviour:
- Reset (rstn = 0, asynchronous):
  - state = IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, ld_done, ld_done_pc, ld_data, st_done, st_done_pc, busy, err.
  - Internal registers cleared: streak counter, timeout counter, latched PC.
  - Reset asserted mid-access drops mem_req immediately. The in-flight access is abandoned and no done pulse is produced after reset releases.
- States: IDLE, LD_WAIT, ST_WAIT.
- Arbitration (IDLE only; ld_ready and st_ready are combinational and both are 0 outside IDLE). Rules are applied in priority order, and at most one of ld_ready/st_ready is 1:
  1. Hazard: if st_valid & ld_valid & (st_addr[31:2] == ld_addr[31:2]), the store wins.
  2. Starvation: if st_valid & streak == STARVE_LIMIT, the store wins.
  3. Otherwise, if ld_valid, the load wins.
  4. Otherwise, if st_valid, the store wins.
- Streak counter (8 bits):
  - Increments on a load grant while st_valid = 1.
  - Clears on any store grant, and on any cycle where st_valid = 0.
  - Saturates at 255.
- On load grant:
  - Next state LD_WAIT; mem_req = 1, mem_we = 0, mem_addr = ld_addr.
  - ld_pc is latched.
- On store grant:
  - Next state ST_WAIT; mem_req = 1, mem_we = 1, mem_addr = st_addr, mem_wdata = st_data.
  - st_pc is latched.
- mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled.
- On a cycle in LD_WAIT with mem_ack = 1:
  - Next cycle: ld_done = 1, ld_done_pc = latched PC, ld_data = mem_rdata captured from the ack cycle.
  - mem_req = 0 and state = IDLE.
- On a cycle in ST_WAIT with mem_ack = 1: next cycle st_done = 1, st_done_pc = latched PC, mem_req = 0, state = IDLE.
- Minimum latency: grant at edge N, mem_req high in cycle N+1, ack in cycle N+1, done pulse in cycle N+2.
- A new grant is permitted in the same cycle as a done pulse, giving back-to-back throughput of one access per 2 cycles at zero memory wait.
- ld_done_pc, ld_data and st_done_pc hold their last values after the pulse.
- Timeout:
  - Counter clears on grant and increments each WAIT cycle without mem_ack.
  - On reaching TIMEOUT: err = 1 (sticky). The state remains in WAIT; the request keeps waiting for ack.
- mem_ack while mem_req = 0 is ignored.
- Requester inputs may change freely while not accepted; they are latched only at the grant.

Test Plan:
- Reset mid-access: load granted, rstn pulled low before ack → mem_req = 0 asynchronously; after release, state IDLE, no ld_done, err = 0.
- Single load, zero wait: ld_valid with ld_pc = 0x10, ld_addr = 0x100; memory acks in the first mem_req cycle with rdata = 0xDEADBEEF → ld_done two cycles after the grant, ld_done_pc = 0x10, ld_data = 0xDEADBEEF.
- Address hazard: load to 0x200 and store to 0x203 (data 0x55) presented in the same cycle → store granted first (mem_we = 1, mem_wdata = 0x55), load granted in the cycle st_done pulses.
- Starvation, STARVE_LIMIT = 4: ld_valid held high continuously, store to 0x300 also pending → 4 load grants, then the store is granted, then loads resume.
- Wait states: ack delayed 5 cycles → mem_addr/mem_we/mem_wdata stable for all 6 request cycles; exactly one done pulse; ld_ready = st_ready = 0 throughout.
- Timeout, TIMEOUT = 8: ack withheld → err rises exactly 8 WAIT cycles after the grant and stays 1; a later ack completes the access normally and err remains 1.
